// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard scoreboard and the decoder that feeds it.
// LAT_LOAD is the latency the decoder drives on id_lat for loads.
package hazard_scoreboard_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int LAT_LOAD   = 1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Per-entry update selected each cycle; flush outranks load outranks decrement.
   typedef enum logic [1:0] {
      SB_DECR  = 2'd0,
      SB_LOAD  = 2'd1,
      SB_FLUSH = 2'd2
   } sb_op_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard.
// The master modport is the decoder; the slave modport is the scoreboard.
interface hazard_scoreboard_if
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int LAT_W    = 3
) ();

   logic                id_valid;
   reg_addr_t           id_rs1;
   reg_addr_t           id_rs2;
   logic                id_use_rs1;
   logic                id_use_rs2;
   reg_addr_t           id_rd;
   logic                id_reg_write;
   logic [LAT_W-1:0]    id_lat;
   logic                ex_flush;
   logic                stall;
   logic [NUM_REGS-1:0] busy_vec;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_lat, ex_flush,
      input  stall, busy_vec
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             id_rd, id_reg_write, id_lat, ex_flush,
      output stall, busy_vec
   );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One register's countdown of cycles until its pending result becomes forwardable.
module sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  sb_op_e           op,
   input  logic [LAT_W-1:0] lat,
   output logic [LAT_W-1:0] count
);

   logic [LAT_W-1:0] dec;

   assign dec = (count == '0) ? '0 : count - LAT_W'(1);

   // A reload keeps whichever completion is later so WAW never shortens a wait.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else begin
         case (op)
            SB_FLUSH: count <= '0;
            SB_LOAD:  count <= (lat > dec) ? lat : dec;
            default:  count <= dec;
         endcase
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight writes and stalls dependent instructions.
// Optional macro HAZARD_STALL_STATS_EN adds a saturating stall_cycles counter output.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int LAT_W    = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   hazard_scoreboard_if.slave   sb
`ifdef HAZARD_STALL_STATS_EN
   ,
   output logic [31:0]          stall_cycles
`endif
);

   logic [LAT_W-1:0] counter [NUM_REGS];
   sb_op_e           op [1:NUM_REGS-1];
   reg_addr_t        last_rd;
   logic             last_vld;
   logic             haz1;
   logic             haz2;
   logic             stall_int;
   logic             issue;
   logic             wr_en;

   assign counter[0] = '0;

   // Hazards read the counters before this cycle's update, so rd==rs sees the old value.
   always_comb begin
      haz1      = sb.id_use_rs1 && (sb.id_rs1 != '0) && (counter[sb.id_rs1] != '0);
      haz2      = sb.id_use_rs2 && (sb.id_rs2 != '0) && (counter[sb.id_rs2] != '0);
      stall_int = sb.id_valid && (haz1 || haz2) && !sb.ex_flush;
      issue     = sb.id_valid && !stall_int && !sb.ex_flush;
      wr_en     = issue && sb.id_reg_write && (sb.id_rd != '0);
   end

   always_comb begin
      for (int i = 1; i < NUM_REGS; i++) begin
         op[i] = SB_DECR;
         if (wr_en && (sb.id_rd == REG_ADDR_W'(i))) begin
            op[i] = SB_LOAD;
         end
         if (sb.ex_flush && last_vld && (last_rd == REG_ADDR_W'(i))) begin
            op[i] = SB_FLUSH;
         end
      end
   end

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      sb_entry #(.LAT_W(LAT_W)) u_entry (
         .clk   (clk),
         .rst   (rst),
         .op    (op[g]),
         .lat   (sb.id_lat),
         .count (counter[g])
      );
   end

   // Remember what issued last cycle so a flush from EX can cancel its write.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_rd  <= '0;
         last_vld <= 1'b0;
      end else begin
         last_rd  <= sb.id_rd;
         last_vld <= wr_en;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         sb.busy_vec[i] = (counter[i] != '0);
      end
   end

   assign sb.stall = stall_int;

`ifdef HAZARD_STALL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (stall_int && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios followed by random traffic,
// compared against a model that tracks the absolute cycle each register becomes ready.
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;

   localparam int NUM_REGS = 32;
   localparam int LAT_W    = 3;

   logic clk = 1'b0;
   logic rst;

   hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .LAT_W(LAT_W)) sb_bus ();

`ifdef HAZARD_STALL_STATS_EN
   logic [31:0] stall_cycles;
`endif

   hazard_scoreboard #(.NUM_REGS(NUM_REGS), .LAT_W(LAT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .sb           (sb_bus)
`ifdef HAZARD_STALL_STATS_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int     vectors     = 0;
   int     miscompares = 0;
   longint ready_at [NUM_REGS];
   longint now;
   int     last_rd_m;
   bit     last_vld_m;
   longint stats_m;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit modelBusy(input int r);
      return (r != 0) && (ready_at[r] > now);
   endfunction

   // One pipeline cycle: drive, check against the model, then advance the model.
   task automatic applyStimulus(input bit r_in, input bit v, input int rs1, input bit u1,
                                input int rs2, input bit u2, input int rd, input bit we,
                                input int lat, input bit fl, output bit got_stall);
      logic [NUM_REGS-1:0] exp_busy;
      bit exp_stall;
      bit issue;
      @(negedge clk);
      rst                 = r_in;
      sb_bus.id_valid     = v;
      sb_bus.id_rs1       = 5'(rs1);
      sb_bus.id_use_rs1   = u1;
      sb_bus.id_rs2       = 5'(rs2);
      sb_bus.id_use_rs2   = u2;
      sb_bus.id_rd        = 5'(rd);
      sb_bus.id_reg_write = we;
      sb_bus.id_lat       = LAT_W'(lat);
      sb_bus.ex_flush     = fl;
      #1;
      for (int i = 0; i < NUM_REGS; i++) exp_busy[i] = modelBusy(i);
      exp_stall = v && ((u1 && modelBusy(rs1)) || (u2 && modelBusy(rs2))) && !fl;
      checkOutput("stall", 64'(sb_bus.stall), 64'(exp_stall));
      checkOutput("busy_vec", 64'(sb_bus.busy_vec), 64'(exp_busy));
`ifdef HAZARD_STALL_STATS_EN
      checkOutput("stall_cycles", 64'(stall_cycles), 64'(stats_m));
`endif
      got_stall = sb_bus.stall;
      if (r_in) begin
         foreach (ready_at[i]) ready_at[i] = 0;
         last_vld_m = 1'b0;
         stats_m    = 0;
      end else begin
         if (exp_stall && stats_m != 64'hFFFF_FFFF) stats_m++;
         if (fl && last_vld_m) ready_at[last_rd_m] = 0;
         issue = v && !exp_stall && !fl;
         if (issue && we && rd != 0 && (now + lat + 1) > ready_at[rd])
            ready_at[rd] = now + lat + 1;
         last_vld_m = issue && we && (rd != 0);
         last_rd_m  = rd;
      end
      now++;
   endtask

   task automatic issueOp(input int rd, input int lat);
      bit s;
      applyStimulus(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, rd, 1'b1, lat, 1'b0, s);
   endtask

   task automatic idleCycles(input int n);
      bit s;
      for (int k = 0; k < n; k++)
         applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, s);
   endtask

   // Hold a dependent instruction in ID until it issues and count its stall cycles.
   task automatic runDependent(input string tag, input int rs, input bit via_rs2, input int exp_len);
      bit s;
      int n = 0;
      for (int k = 0; k < 12; k++) begin
         if (via_rs2)
            applyStimulus(1'b0, 1'b1, 0, 1'b0, rs, 1'b1, 0, 1'b0, 0, 1'b0, s);
         else
            applyStimulus(1'b0, 1'b1, rs, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, s);
         if (!s) break;
         n++;
      end
      checkOutput(tag, 64'(n), 64'(exp_len));
   endtask

   initial begin
      bit s;
      rst                 = 1'b1;
      sb_bus.id_valid     = 1'b0;
      sb_bus.id_rs1       = '0;
      sb_bus.id_rs2       = '0;
      sb_bus.id_use_rs1   = 1'b0;
      sb_bus.id_use_rs2   = 1'b0;
      sb_bus.id_rd        = '0;
      sb_bus.id_reg_write = 1'b0;
      sb_bus.id_lat       = '0;
      sb_bus.ex_flush     = 1'b0;
      foreach (ready_at[i]) ready_at[i] = 0;
      now        = 0;
      last_rd_m  = 0;
      last_vld_m = 1'b0;
      stats_m    = 0;
      repeat (2) @(posedge clk);

      idleCycles(1);

      issueOp(5, LAT_LOAD);
      runDependent("load_use_len", 5, 1'b0, 1);

      issueOp(7, 0);
      runDependent("alu_b2b_len", 7, 1'b1, 0);

      issueOp(3, 4);
      issueOp(3, 1);
      runDependent("waw_len", 3, 1'b0, 3);

      issueOp(9, 3);
      applyStimulus(1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1, s);
      runDependent("flush_len", 9, 1'b0, 0);

      issueOp(0, 5);
      issueOp(6, 5);
      applyStimulus(1'b0, 1'b1, 6, 1'b0, 6, 1'b0, 0, 1'b0, 0, 1'b0, s);
      checkOutput("unused_operand", 64'(s), 64'(0));
      runDependent("x0_len", 0, 1'b0, 0);
      idleCycles(6);

      issueOp(4, 3);
      applyStimulus(1'b1, 1'b1, 4, 1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, s);
      checkOutput("stall_before_reset", 64'(s), 64'(1));
      runDependent("after_reset_len", 4, 1'b0, 0);

      for (int k = 0; k < 600; k++) begin
         applyStimulus($urandom_range(0, 63) == 0,
                       $urandom_range(0, 7) != 0,
                       int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                       int'($urandom_range(0, 7)),
                       $urandom_range(0, 7) == 0, s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Producer-side complement to the EX-stage operand forwarding logic.
- Tracks every in-flight register write (loads and multi-cycle ops) by destination and remaining cycles until its result is forwardable.
- Stalls the ID stage when a decoded source operand is not yet forwardable.
- Sits between decode and the ID/EX pipeline register; forwarding mux selects continue to be computed downstream.

Parameters:
- NUM_REGS, 32, architectural registers; x0 is never tracked.
- LAT_W, 3, width of each countdown counter; maximum latency 2^LAT_W-1.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a valid instruction.
- id_rs1  input  5  source register 1.
- id_rs2  input  5  source register 2.
- id_use_rs1  input  1  instruction reads rs1.
- id_use_rs2  input  1  instruction reads rs2.
- id_rd  input  5  destination register.
- id_reg_write  input  1  instruction writes rd.
- id_lat  input  LAT_W  cycles after issue until the rd result is forwardable (0 = forwardable next cycle, ALU ops).
- ex_flush  input  1  kill the instruction issued on the previous cycle (branch or jump resolved in EX).
- stall  output  1  hold PC and IF/ID, insert bubble into ID/EX.
- busy_vec  output  NUM_REGS  bit i set when counter[i] != 0.

Behaviour:
- Reset and the interface are as decided: one clock; reset is synchronous and active-high.
- State: counter[1..NUM_REGS-1] of LAT_W bits; last_rd (5 bits); last_vld (1 bit).
- Reset (rst=1 at a clk edge): all counters 0, last_vld 0. stall=0 and busy_vec=0 from the following cycle. Reset mid-operation discards all pending entries.
- Hazard (combinational): haz1 = id_use_rs1 && id_rs1!=0 && counter[id_rs1]!=0; same form for haz2.
- stall = id_valid && (haz1 || haz2) && !ex_flush.
- Issue: issue = id_valid && !stall && !ex_flush.
- Per-cycle counter update, in priority order:
  1. ex_flush && last_vld: counter[last_rd] <= 0 (flushed instruction never writes).
  2. issue && id_reg_write && id_rd!=0: counter[id_rd] <= max(id_lat, counter[id_rd]-1, saturating at 0). WAW keeps the later completion.
  3. Otherwise, any nonzero counter decrements by 1.
- Issue to a register takes priority over that register's decrement in the same cycle.
- Flush and issue in the same cycle: issue is suppressed, so only the flush takes effect.
- last_rd <= id_rd and last_vld <= issue && id_reg_write && id_rd!=0 every cycle. On flush, last_vld <= 0.
- Self-dependency: rd==rs1 on the same instruction checks the old counter value, before the update.
- Latency: an issue with id_lat=N raises stall for a dependent instruction in ID for exactly N cycles. id_lat=0 never stalls.
- Counters never wrap: a decrement at 0 stays 0.
- x0: counter is not implemented and reads as 0; writes to x0 are ignored.

Optional Feature:
- Macro: HAZARD_STALL_STATS_EN.
- Defined: adds output stall_cycles (32 bits), reset to 0, incremented on every cycle with stall=1. Saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Shared package (cpu_pkg) holds REG_ADDR_W=5 and a LAT_LOAD constant (=1), consumed by the decoder to drive id_lat.
- One natural sub-module: sb_entry, a single register's counter with load/flush/decrement priority, instantiated for indices 1..NUM_REGS-1.

Test Plan:
- Load-use: issue rd=5, lat=1; next cycle rs1=5, use_rs1=1 -> stall=1 for 1 cycle, then issue; busy_vec[5] 1 then 0.
- ALU back-to-back: rd=7, lat=0, then rs2=7 -> stall never asserted.
- Multi-cycle WAW: rd=3 lat=4, then rd=3 lat=1 -> counter[3] keeps max(3,1)=3; dependent on x3 stalls 3 cycles.
- Flush: issue rd=9 lat=3, next cycle ex_flush=1 -> counter[9]=0, busy_vec[9]=0, no stall on x9 afterwards.
- x0 and unused operand: rd=0 lat=5 -> busy_vec unchanged; rs1=busy reg with use_rs1=0 -> stall=0.
- Reset mid-stall: counter[4]=3 with stall=1, assert rst one cycle -> stall=0 and busy_vec=0 next cycle; with HAZARD_STALL_STATS_EN, stall_cycles=0.
